// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin over WIDTH bits, DIGIT bits per
// clock, with the inter-digit borrow held in a flip-flop.
// Optional build macro SERIAL_SUB_ABS_DIFF_EN adds a FIX state that returns
// |a - b - bin| in diff when the final borrow is set (bout still reports 1).
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

`ifdef SERIAL_SUB_ABS_DIFF_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] work;
    logic             borrow_ff;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic [DIGIT:0]   dig_res;
    logic             borrow_nxt;
    logic [WIDTH-1:0] work_nxt;
    logic             last_dig;

    // One digit of the borrow chain; the new digit enters the working register at the MSB end
    always_comb begin
        dig_res    = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]}
                     - {{DIGIT{1'b0}}, borrow_ff};
        borrow_nxt = dig_res[DIGIT];
        work_nxt   = (work >> DIGIT) | (WIDTH'(dig_res[DIGIT-1:0]) << (WIDTH - DIGIT));
        last_dig   = (cnt == CNT_W'(NDIG - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so a start while busy is dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_dig) begin
`ifdef SERIAL_SUB_ABS_DIFF_EN
                    state_nxt = FIX;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef SERIAL_SUB_ABS_DIFF_EN
            FIX: begin
                state_nxt = DONE;
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, digit-serial datapath and result registers (loaded on the edge entering DONE)
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            work      <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr      <= a;
                        b_sr      <= b;
                        work      <= '0;
                        borrow_ff <= bin;
                        cnt       <= '0;
                        a_msb     <= a[WIDTH-1];
                        b_msb     <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sr      <= a_sr >> DIGIT;
                    b_sr      <= b_sr >> DIGIT;
                    work      <= work_nxt;
                    borrow_ff <= borrow_nxt;
                    cnt       <= cnt + CNT_W'(1);
`ifndef SERIAL_SUB_ABS_DIFF_EN
                    if (last_dig) begin
                        diff <= work_nxt;
                        bout <= borrow_nxt;
                        ovf  <= (a_msb != b_msb) && (work_nxt[WIDTH-1] != a_msb);
                    end
`endif
                end
`ifdef SERIAL_SUB_ABS_DIFF_EN
                FIX: begin
                    // Overflow is judged on the raw difference, before any negation
                    work <= borrow_ff ? ('0 - work) : work;
                    diff <= borrow_ff ? ('0 - work) : work;
                    bout <= borrow_ff;
                    ovf  <= (a_msb != b_msb) && (work[WIDTH-1] != a_msb);
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a DIGIT=1 and a DIGIT=4 instance (WIDTH=8),
// table-driven vectors through an expected-result queue, plus busy/reset sequences.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       bin = 1'b0;

    logic       busy1, done1, bout1, ovf1;
    logic [7:0] diff1;
    logic       busy4, done4, bout4, ovf4;
    logic [7:0] diff4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];
    vec_t vecs4[3];

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic dn(input bit d4);
        return d4 ? done4 : done1;
    endfunction

    function automatic logic bz(input bit d4);
        return d4 ? busy4 : busy1;
    endfunction

    function automatic logic [7:0] dv(input bit d4);
        return d4 ? diff4 : diff1;
    endfunction

    function automatic logic [9:0] outs(input bit d4);
        return d4 ? {busy4, done4, diff4} : {busy1, done1, diff1};
    endfunction

    function automatic logic [1:0] flags(input bit d4);
        return d4 ? {bout4, ovf4} : {bout1, ovf1};
    endfunction

    // Drive one operation; inject = cycle at which a stray start with a=FF is raised,
    // rstc = cycle at which rst is raised (abort). Negative disables either.
    task automatic run_op(input bit d4, input vec_t v, input int inject, input int rstc);
        exp_t       e;
        exp_t       got;
        int         k;
        int         nd;
        int         ndig;
        bit         aborted;
        logic [7:0] prev;
        ndig = d4 ? 2 : 8;
        e.d  = v.d;
        e.bo = v.bo;
        e.ov = v.ov;
`ifdef SERIAL_SUB_ABS_DIFF_EN
        if (v.bo) e.d = ~v.d + 8'd1;
        e.lat = ndig + 2;
`else
        e.lat = ndig + 1;
`endif
        sbq.push_back(e);
        aborted = 1'b0;

        @(negedge clk);
        a = v.a; b = v.b; bin = v.bin;
        if (d4) start4 = 1'b1; else start1 = 1'b1;
        prev = dv(d4);
        @(posedge clk);
        k = 1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        a = ~v.a; b = ~v.b; bin = ~v.bin;
        chk("busy_in_run", 32'(bz(d4)), 32'd1);

        while (!dn(d4) && k < 40 && !aborted) begin
            if (k == inject) begin
                a = 8'hFF;
                if (d4) start4 = 1'b1; else start1 = 1'b1;
            end
            if (k == rstc) rst = 1'b1;
            @(posedge clk);
            k++;
            @(negedge clk);
            start1 = 1'b0; start4 = 1'b0;
            if (rst) begin
                rst = 1'b0;
                aborted = 1'b1;
            end
            if (!d4 && k == 3 && !aborted) chk("diff_hold_in_run", 32'(dv(d4)), 32'(prev));
        end

        if (aborted) begin
            void'(sbq.pop_front());
            chk("rst_abort_outs", 32'(outs(d4)), 32'd0);
            chk("rst_abort_flags", 32'(flags(d4)), 32'd0);
            nd = 0;
            repeat (12) begin
                @(negedge clk);
                if (dn(d4)) nd++;
            end
            chk("no_done_after_rst", 32'(nd), 32'd0);
            return;
        end

        got = sbq.pop_front();
        if (!dn(d4)) begin
            chk("done_timeout", 32'(k), 32'(got.lat));
            return;
        end
        chk("latency", 32'(k), 32'(got.lat));
        chk("diff", 32'(dv(d4)), 32'(got.d));
        chk("bout_ovf", 32'(flags(d4)), 32'({got.bo, got.ov}));
        @(negedge clk);
        chk("done_one_cycle", 32'(dn(d4)), 32'd0);
        chk("idle_after_done", 32'(bz(d4)), 32'd0);
        chk("diff_held", 32'(dv(d4)), 32'(got.d));
    endtask

    initial begin
        vec_t hv;
        //          a      b      bin   raw diff bout ovf
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[7] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1};
        vecs[9] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};

        vecs4[0] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs4[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs4[2] = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_outs_d1", 32'(outs(1'b0)), 32'd0);
        chk("reset_flags_d1", 32'(flags(1'b0)), 32'd0);
        chk("reset_outs_d4", 32'(outs(1'b1)), 32'd0);
        chk("reset_flags_d4", 32'(flags(1'b1)), 32'd0);

        for (int i = 0; i < 10; i++) run_op(1'b0, vecs[i], -1, -1);
        for (int i = 0; i < 3; i++) run_op(1'b1, vecs4[i], -1, -1);

        // Start while busy is ignored and the first result is unaffected
        hv = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        run_op(1'b0, hv, 4, -1);

        // Reset in the middle of an operation aborts it
        hv = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        run_op(1'b0, hv, -1, 5);

        // A fresh operation after the abort completes normally
        hv = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        run_op(1'b0, hv, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
